// File: rtl/iob_fifo_sync_asym_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : iob_fifo_sync_asym_ctrl                                      |
// | Brief   : Synchronous FIFO controller for an asymmetric two-port RAM.  |
// |           Owns write/read pointers and fill level; RAM data buses      |
// |           connect directly between user and RAM.                       |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module iob_fifo_sync_asym_ctrl #(
  parameter  int W_DATA_W  = 32,
  parameter  int R_DATA_W  = 8,
  parameter  int ADDR_W    = 4,
  localparam int MINDATA_W = (W_DATA_W < R_DATA_W) ? W_DATA_W : R_DATA_W,
  localparam int W_RATIO   = W_DATA_W / MINDATA_W,
  localparam int R_RATIO   = R_DATA_W / MINDATA_W,
  localparam int W_ADDR_W  = ADDR_W - $clog2(W_RATIO),
  localparam int R_ADDR_W  = ADDR_W - $clog2(R_RATIO)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                w_en,
  output logic                w_full,
  input  logic                r_en,
  output logic                r_empty,
  output logic                r_valid,
  output logic [ADDR_W:0]     level,
  output logic                w_overflow,
  output logic                r_underflow,
  output logic                mem_w_en,
  output logic [W_ADDR_W-1:0] mem_w_addr,
  output logic                mem_r_en,
  output logic [R_ADDR_W-1:0] mem_r_addr
);

  // Level increments/decrements and full threshold, all in minimum-width units
  localparam logic [ADDR_W:0] c_w_inc    = (ADDR_W+1)'(W_RATIO);
  localparam logic [ADDR_W:0] c_r_dec    = (ADDR_W+1)'(R_RATIO);
  localparam logic [ADDR_W:0] c_full_thr = (ADDR_W+1)'((2**ADDR_W) - W_RATIO);

  logic [W_ADDR_W-1:0] wptr_q, wptr_d;
  logic [R_ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]     level_q, level_d;
  logic                r_valid_q, r_valid_d;
  logic                w_overflow_q, w_overflow_d;
  logic                r_underflow_q, r_underflow_d;
  logic                wr_acc, rd_acc;

  // Flags come only from the stored level; pointers are free to wrap
  assign w_full  = (level_q > c_full_thr);
  assign r_empty = (level_q < c_r_dec);

  // clr suppresses any RAM access in its cycle
  assign wr_acc = w_en & ~w_full & ~clr;
  assign rd_acc = r_en & ~r_empty & ~clr;

  assign mem_w_en    = wr_acc;
  assign mem_w_addr  = wptr_q;
  assign mem_r_en    = rd_acc;
  assign mem_r_addr  = rptr_q;
  assign level       = level_q;
  assign r_valid     = r_valid_q;
  assign w_overflow  = w_overflow_q;
  assign r_underflow = r_underflow_q;

  // Next-state: pointer advance, level accounting, read-valid delay, sticky errors
  always_comb begin
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    level_d       = level_q + (wr_acc ? c_w_inc : '0) - (rd_acc ? c_r_dec : '0);
    r_valid_d     = rd_acc;
    w_overflow_d  = w_overflow_q | (w_en & w_full);
    r_underflow_d = r_underflow_q | (r_en & r_empty);
    if (wr_acc) begin
      wptr_d = wptr_q + W_ADDR_W'(1);
    end
    if (rd_acc) begin
      rptr_d = rptr_q + R_ADDR_W'(1);
    end
    if (clr) begin
      wptr_d        = '0;
      rptr_d        = '0;
      level_d       = '0;
      r_valid_d     = 1'b0;
      w_overflow_d  = 1'b0;
      r_underflow_d = 1'b0;
    end
  end

  // State registers; asynchronous reset also drops r_valid immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      level_q       <= '0;
      r_valid_q     <= 1'b0;
      w_overflow_q  <= 1'b0;
      r_underflow_q <= 1'b0;
    end else begin
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      level_q       <= level_d;
      r_valid_q     <= r_valid_d;
      w_overflow_q  <= w_overflow_d;
      r_underflow_q <= r_underflow_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iob_fifo_sync_asym_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_iob_fifo_sync_asym_ctrl                                   |
// | Brief   : Directed bench: 32->8 instance driven from a vector table    |
// |           plus wrap/reset sequences; 8->32 instance hand sequence.     |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tb_iob_fifo_sync_asym_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ---------------- 32 -> 8 instance ----------------
  logic        a_clr, a_w_en, a_r_en;
  logic        a_w_full, a_r_empty, a_r_valid, a_ovf, a_unf;
  logic [4:0]  a_level;
  logic        a_mwen, a_mren;
  logic [1:0]  a_mwaddr;
  logic [3:0]  a_mraddr;
  logic [31:0] a_w_data;
  logic [7:0]  a_r_data;
  logic [7:0]  mem_a [0:15];

  iob_fifo_sync_asym_ctrl #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(a_clr),
    .w_en(a_w_en), .w_full(a_w_full),
    .r_en(a_r_en), .r_empty(a_r_empty), .r_valid(a_r_valid),
    .level(a_level), .w_overflow(a_ovf), .r_underflow(a_unf),
    .mem_w_en(a_mwen), .mem_w_addr(a_mwaddr),
    .mem_r_en(a_mren), .mem_r_addr(a_mraddr)
  );

  // Asymmetric RAM model: wide word stored LSB byte first, registered narrow read
  always @(posedge clk) begin
    if (a_mren) a_r_data <= mem_a[a_mraddr];
    if (a_mwen)
      for (int k = 0; k < 4; k++) mem_a[int'(a_mwaddr) * 4 + k] <= a_w_data[8*k +: 8];
  end

  // ---------------- 8 -> 32 instance ----------------
  logic        b_clr, b_w_en, b_r_en;
  logic        b_w_full, b_r_empty, b_r_valid, b_ovf, b_unf;
  logic [4:0]  b_level;
  logic        b_mwen, b_mren;
  logic [3:0]  b_mwaddr;
  logic [1:0]  b_mraddr;
  logic [7:0]  b_w_data;
  logic [31:0] b_r_data;
  logic [7:0]  mem_b [0:15];

  iob_fifo_sync_asym_ctrl #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(b_clr),
    .w_en(b_w_en), .w_full(b_w_full),
    .r_en(b_r_en), .r_empty(b_r_empty), .r_valid(b_r_valid),
    .level(b_level), .w_overflow(b_ovf), .r_underflow(b_unf),
    .mem_w_en(b_mwen), .mem_w_addr(b_mwaddr),
    .mem_r_en(b_mren), .mem_r_addr(b_mraddr)
  );

  // Narrow writes fill a wide word from its LSBs upward
  always @(posedge clk) begin
    if (b_mwen) mem_b[b_mwaddr] <= b_w_data;
    if (b_mren) b_r_data <= {mem_b[{b_mraddr, 2'd3}], mem_b[{b_mraddr, 2'd2}],
                             mem_b[{b_mraddr, 2'd1}], mem_b[{b_mraddr, 2'd0}]};
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s [%0d]: got %0h, expected %0h", nm, idx, act, exp);
    end
  endtask

  typedef struct {
    logic        clr, w, r;
    logic [31:0] wd;
    logic [4:0]  lvl;
    logic        wf, re, mwen;
    logic [1:0]  wa;
    logic        mren;
    logic [3:0]  ra;
    logic        rv;
    logic [7:0]  rd;
    logic        ovf, unf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int clr, input int w, input int r, input logic [31:0] wd,
                     input int lvl, input int wf, input int re, input int mwen,
                     input int wa, input int mren, input int ra, input int rv,
                     input int rd, input int ovf, input int unf);
    vec_t v;
    v.clr = clr[0];  v.w = w[0];  v.r = r[0];  v.wd = wd;
    v.lvl = lvl[4:0]; v.wf = wf[0]; v.re = re[0]; v.mwen = mwen[0];
    v.wa = wa[1:0];  v.mren = mren[0]; v.ra = ra[3:0]; v.rv = rv[0];
    v.rd = rd[7:0];  v.ovf = ovf[0]; v.unf = unf[0];
    vecs.push_back(v);
  endtask

  function automatic logic [7:0] pat(input int p, input int k);
    return 8'(p * 37 + k * 5 + 3);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    a_clr = 0; a_w_en = 0; a_r_en = 0; a_w_data = '0;
    b_clr = 0; b_w_en = 0; b_r_en = 0; b_w_data = '0;

    // Vector table for the 32->8 instance: inputs, then outputs seen in that cycle
    //   clr w r wdata          lvl wf re mwen wa mren ra rv rd ovf unf
    add(0,1,0,32'h03020100,  0, 0,1, 1,0, 0,0, 0,0,    0,0);
    add(0,1,0,32'h07060504,  4, 0,0, 1,1, 0,0, 0,0,    0,0);
    add(0,1,0,32'h0B0A0908,  8, 0,0, 1,2, 0,0, 0,0,    0,0);
    add(0,1,0,32'h0F0E0D0C, 12, 0,0, 1,3, 0,0, 0,0,    0,0);
    add(0,1,0,32'h11111111, 16, 1,0, 0,0, 0,0, 0,0,    0,0);
    add(0,0,1,32'h0,        16, 1,0, 0,0, 1,0, 0,0,    1,0);
    add(0,0,1,32'h0,        15, 1,0, 0,0, 1,1, 1,8'h00,1,0);
    add(0,0,1,32'h0,        14, 1,0, 0,0, 1,2, 1,8'h01,1,0);
    add(0,0,1,32'h0,        13, 1,0, 0,0, 1,3, 1,8'h02,1,0);
    add(0,0,0,32'h0,        12, 0,0, 0,0, 0,4, 1,8'h03,1,0);
    for (int i = 0; i < 12; i++)
      add(0,0,1,32'h0, 12-i, 0,0, 0,0, 1,4+i, (i>0)?1:0, 3+i, 1,0);
    add(0,0,1,32'h0,         0, 0,1, 0,0, 0,0, 1,8'h0F,1,0);
    add(0,0,0,32'h0,         0, 0,1, 0,0, 0,0, 0,0,    1,1);
    add(0,1,0,32'h13121110,  0, 0,1, 1,0, 0,0, 0,0,    1,1);
    add(0,1,0,32'h17161514,  4, 0,0, 1,1, 0,0, 0,0,    1,1);
    add(0,1,1,32'h1B1A1918,  8, 0,0, 1,2, 1,0, 0,0,    1,1);
    add(0,0,0,32'h0,        11, 0,0, 0,3, 0,1, 1,8'h10,1,1);
    add(0,0,1,32'h0,        11, 0,0, 0,3, 1,1, 0,0,    1,1);
    add(0,0,1,32'h0,        10, 0,0, 0,3, 1,2, 1,8'h11,1,1);
    add(0,0,1,32'h0,         9, 0,0, 0,3, 1,3, 1,8'h12,1,1);
    add(0,1,0,32'h1F1E1D1C,  8, 0,0, 1,3, 0,4, 1,8'h13,1,1);
    add(1,1,1,32'hDEADBEEF, 12, 0,0, 0,0, 0,4, 0,0,    1,1);
    add(0,0,0,32'h0,         0, 0,1, 0,0, 0,0, 0,0,    0,0);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 8->32: three narrow writes are not yet a full read word
    @(negedge clk); b_w_en = 1; b_w_data = 8'hAA; #1;
    chk("b_reset_level", 0, 32'(b_level), 0);
    chk("b_reset_empty", 0, 32'(b_r_empty), 1);
    chk("b_mwen", 0, 32'(b_mwen), 1);
    chk("b_mwaddr", 0, 32'(b_mwaddr), 0);
    @(negedge clk); b_w_data = 8'hBB; #1;
    chk("b_mwaddr", 1, 32'(b_mwaddr), 1);
    @(negedge clk); b_w_data = 8'hCC; #1;
    chk("b_mwaddr", 2, 32'(b_mwaddr), 2);
    @(negedge clk); b_w_en = 0; b_r_en = 1; #1;
    chk("b_level3", 0, 32'(b_level), 3);
    chk("b_empty_at3", 0, 32'(b_r_empty), 1);
    chk("b_mren_rejected", 0, 32'(b_mren), 0);
    @(negedge clk); b_r_en = 0; b_w_en = 1; b_w_data = 8'hDD; #1;
    chk("b_underflow", 0, 32'(b_unf), 1);
    chk("b_rvalid_after_reject", 0, 32'(b_r_valid), 0);
    chk("b_mwaddr", 3, 32'(b_mwaddr), 3);
    @(negedge clk); b_w_en = 0; b_r_en = 1; #1;
    chk("b_level4", 0, 32'(b_level), 4);
    chk("b_empty_at4", 0, 32'(b_r_empty), 0);
    chk("b_mren", 0, 32'(b_mren), 1);
    chk("b_mraddr", 0, 32'(b_mraddr), 0);
    @(negedge clk); b_r_en = 0; #1;
    chk("b_rvalid", 0, 32'(b_r_valid), 1);
    chk("b_rdata", 0, b_r_data, 32'hDDCCBBAA);
    chk("b_level0", 0, 32'(b_level), 0);
    chk("b_empty_end", 0, 32'(b_r_empty), 1);

    // 32->8 vector table
    foreach (vecs[i]) begin
      @(negedge clk);
      a_clr = vecs[i].clr; a_w_en = vecs[i].w; a_r_en = vecs[i].r; a_w_data = vecs[i].wd;
      #1;
      chk("level",      i, 32'(a_level),   32'(vecs[i].lvl));
      chk("w_full",     i, 32'(a_w_full),  32'(vecs[i].wf));
      chk("r_empty",    i, 32'(a_r_empty), 32'(vecs[i].re));
      chk("mem_w_en",   i, 32'(a_mwen),    32'(vecs[i].mwen));
      chk("mem_w_addr", i, 32'(a_mwaddr),  32'(vecs[i].wa));
      chk("mem_r_en",   i, 32'(a_mren),    32'(vecs[i].mren));
      chk("mem_r_addr", i, 32'(a_mraddr),  32'(vecs[i].ra));
      chk("r_valid",    i, 32'(a_r_valid), 32'(vecs[i].rv));
      if (vecs[i].rv) chk("r_data", i, 32'(a_r_data), 32'(vecs[i].rd));
      chk("w_overflow", i, 32'(a_ovf),     32'(vecs[i].ovf));
      chk("r_underflow",i, 32'(a_unf),     32'(vecs[i].unf));
    end
    @(negedge clk); a_clr = 0; a_w_en = 0; a_r_en = 0;

    // Three full fill/drain passes exercise pointer wrap
    for (int p = 0; p < 3; p++) begin
      for (int j = 0; j < 4; j++) begin
        @(negedge clk); a_w_en = 1;
        for (int b = 0; b < 4; b++) a_w_data[8*b +: 8] = pat(p, 4*j + b);
      end
      @(negedge clk); a_w_en = 0; #1;
      chk("wrap_full", p, 32'(a_w_full), 1);
      chk("wrap_level16", p, 32'(a_level), 16);
      for (int k = 0; k <= 16; k++) begin
        @(negedge clk); a_r_en = (k < 16); #1;
        if (k > 0) begin
          chk("wrap_rvalid", p*16 + k, 32'(a_r_valid), 1);
          chk("wrap_rdata", p*16 + k, 32'(a_r_data), 32'(pat(p, k-1)));
        end
      end
      chk("wrap_level0", p, 32'(a_level), 0);
      chk("wrap_empty", p, 32'(a_r_empty), 1);
      chk("wrap_wptr", p, 32'(a_mwaddr), 0);
      chk("wrap_rptr", p, 32'(a_mraddr), 0);
    end

    // Asynchronous reset in the middle of a read
    @(negedge clk); a_w_en = 1; a_w_data = 32'hCAFEF00D;
    @(negedge clk); a_w_en = 0; a_r_en = 1;
    @(negedge clk); a_r_en = 0; a_w_en = 1; #1;
    chk("pre_rst_rvalid", 0, 32'(a_r_valid), 1);
    chk("pre_rst_rdata", 0, 32'(a_r_data), 32'h0D);
    chk("pre_rst_level", 0, 32'(a_level), 3);
    a_w_en = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rvalid", 0, 32'(a_r_valid), 0);
    chk("rst_level", 0, 32'(a_level), 0);
    chk("rst_empty", 0, 32'(a_r_empty), 1);
    chk("rst_full", 0, 32'(a_w_full), 0);
    chk("rst_wptr", 0, 32'(a_mwaddr), 0);
    chk("rst_rptr", 0, 32'(a_mraddr), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/iob_fifo_sync_asym_ctrl.md
Name: iob_fifo_sync_asym_ctrl

Overview:
- Synchronous FIFO controller for an asymmetric two-port RAM (independent write and read data widths) in the same clock domain.
- Owns the write and read pointers and the fill-level accounting.
- Drives the RAM's write enable/address and read enable/address. Data buses connect directly between the user and the RAM; they never pass through this block.
- Used wherever a width-converting buffer is needed, e.g. 32-bit bus writes feeding an 8-bit serial consumer.

Parameters:
- W_DATA_W, 32, write port width; power of two.
- R_DATA_W, 8, read port width; power of two.
- ADDR_W, 4, address width in units of MIN(W_DATA_W,R_DATA_W). Capacity is 2**ADDR_W minimum-width units.
- Derived (localparam): MINDATA_W, W_RATIO = W_DATA_W/MINDATA_W, R_RATIO = R_DATA_W/MINDATA_W, W_ADDR_W = ADDR_W-log2(W_RATIO), R_ADDR_W = ADDR_W-log2(R_RATIO).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear; has priority over w_en/r_en
- w_en  in  1  write request
- w_full  out  1  no room for one W_DATA_W word
- r_en  in  1  read request
- r_empty  out  1  fewer than R_RATIO units stored
- r_valid  out  1  RAM r_data valid this cycle
- level  out  ADDR_W+1  stored minimum-width units
- w_overflow  out  1  sticky: write attempted while full
- r_underflow  out  1  sticky: read attempted while empty
- mem_w_en  out  1  RAM write enable
- mem_w_addr  out  W_ADDR_W  RAM write address
- mem_r_en  out  1  RAM read enable
- mem_r_addr  out  R_ADDR_W  RAM read address

Behaviour:
- Reset (rst_n low, asynchronous) and clr (synchronous) both set:
  - write pointer = 0, read pointer = 0, level = 0
  - r_valid = 0, w_overflow = 0, r_underflow = 0
  - Resulting outputs: w_full = 0, r_empty = 1.
- Write accept: wr_acc = w_en & ~w_full & ~clr.
  - mem_w_en = wr_acc (combinational).
  - mem_w_addr = write pointer (combinational).
  - Write pointer increments by 1 on wr_acc and wraps at 2**W_ADDR_W.
- Read accept: rd_acc = r_en & ~r_empty & ~clr.
  - mem_r_en = rd_acc (combinational).
  - mem_r_addr = read pointer (combinational).
  - Read pointer increments by 1 on rd_acc and wraps at 2**R_ADDR_W.
- Read latency: the RAM read is registered. r_valid is rd_acc delayed one cycle; the user samples the RAM's r_data while r_valid = 1.
- Level update:
  - next level = level + (wr_acc ? W_RATIO : 0) - (rd_acc ? R_RATIO : 0).
  - Computed at ADDR_W+1 bits; it never exceeds 2**ADDR_W and never goes below 0.
- Flags, combinational from registered level:
  - w_full = (level > 2**ADDR_W - W_RATIO)
  - r_empty = (level < R_RATIO)
  - Both flags use the current-cycle level. A write and a read in the same cycle are both accepted when both flags are clear.
- Rejected requests:
  - w_en while full: ignored; RAM not written; pointers and level unchanged; w_overflow sets and holds until reset/clr.
  - r_en while empty: ignored; r_valid = 0 next cycle; r_underflow sets and holds until reset/clr.
- Ordering: the first-written narrow unit sits in the LSBs of a wide word.
  - Wide write: bytes leave LSB-first on the narrow read port.
  - Narrow write: the first narrow write lands in R_DATA_W[MINDATA_W-1:0].
- Equal widths: behaves as a plain synchronous FIFO with ratio 1.
- Wrap-around: pointers wrap silently. full/empty are derived from level only, never from a pointer comparison.
- clr together with w_en/r_en: clr wins; no RAM access occurs that cycle.
- rst_n asserted mid-read: r_valid drops immediately (asynchronously).

Test Plan:
- W=32,R=8,ADDR_W=4: after reset, 4 writes 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C -> level 4,8,12,16; w_full=1 after 4th. A 5th write -> mem_w_en=0, w_overflow=1.
- Same fill, then 16 reads -> r_valid data 0x00..0x0F in order; r_empty=1 after 16th; level=0. A 17th read -> r_underflow=1, r_valid stays 0.
- W=8,R=32,ADDR_W=4: write 0xAA,0xBB,0xCC -> r_empty=1 (level 3). 4th write 0xDD -> r_empty=0; read returns 0xDDCCBBAA with r_valid one cycle after r_en.
- W=32,R=8: with level=8, assert w_en and r_en together for 1 cycle -> level=8+4-1=11; both pointers advance.
- Wrap: 3 full fill/drain cycles of the 32->8 config -> data is correct every pass; pointers wrap to 0; level returns to 0 each pass.
- clr with level=12 and w_en=1 -> next cycle level=0, r_empty=1, mem_w_en=0 during the clr cycle, sticky flags cleared. rst_n pulse low mid-operation -> same values immediately.
